des_iter_ctrl: RTL

DES_ITER_CTRL -- requirements
Module: des_iter_ctrl

---
 rtl/des_iter_ctrl.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/des_iter_ctrl.sv
// Iterative DES engine: one Feistel round per clock over 16 cycles, with a four-phase req/ack handshake.
// Contains the permutation helpers and the round datapath used by the controller.

module perm_IP (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  localparam logic [8*64-1:0] TBL = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,  8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7};
  for (genvar j = 0; j < 64; j++) begin : g_bit
    assign dout[63-j] = din[64 - int'(TBL[8*(63-j) +: 8])];
  end
endmodule

module perm_FP (
  input  logic [63:0] din,
  output logic [63:0] dout
);
  localparam logic [8*64-1:0] TBL = {
    8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,  8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
    8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,  8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
    8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,  8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,  8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25};
  for (genvar j = 0; j < 64; j++) begin : g_bit
    assign dout[63-j] = din[64 - int'(TBL[8*(63-j) +: 8])];
  end
endmodule

module perm_PC1 (
  input  logic [63:0] din,
  output logic [55:0] dout
);
  localparam logic [8*56-1:0] TBL = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,   8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,  8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,  8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,  8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4};
  // Key parity bits are dropped by the table.
  logic unused_parity_s;
  assign unused_parity_s = ^{din[56], din[48], din[40], din[32], din[24], din[16], din[8], din[0]};
  for (genvar j = 0; j < 56; j++) begin : g_bit
    assign dout[55-j] = din[64 - int'(TBL[8*(55-j) +: 8])];
  end
endmodule

module perm_PC2 (
  input  logic [55:0] din,
  output logic [47:0] dout
);
  localparam logic [8*48-1:0] TBL = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32};
  logic unused_drop_s;
  assign unused_drop_s = ^{din[47], din[38], din[34], din[31], din[21], din[18], din[13], din[2]};
  for (genvar j = 0; j < 48; j++) begin : g_bit
    assign dout[47-j] = din[56 - int'(TBL[8*(47-j) +: 8])];
  end
endmodule

module round (
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [31:0] l_out,
  output logic [31:0] r_out
);
  localparam logic [8*48-1:0] E_TBL = {
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
    8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
    8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1};
  localparam logic [8*32-1:0] P_TBL = {
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17, 8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,  8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25};
  // Each S-box is 4 rows x 16 nibbles, row 0 in the most significant digits.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [47:0] e_s;
  logic [47:0] x_s;
  logic [31:0] s_s;
  logic [31:0] p_s;

  for (genvar j = 0; j < 48; j++) begin : g_e
    assign e_s[47-j] = r_in[32 - int'(E_TBL[8*(47-j) +: 8])];
  end
  assign x_s = e_s ^ subkey;

  // Outer bits pick the row, inner four bits the column.
  always_comb begin
    logic [5:0] six;
    logic [5:0] idx;
    s_s = 32'd0;
    for (int g = 0; g < 8; g++) begin
      six = x_s[47-6*g -: 6];
      idx = {six[5], six[0], six[4:1]};
      s_s[31-4*g -: 4] = SBOX[g][4*(63 - int'(idx)) +: 4];
    end
  end

  for (genvar j = 0; j < 32; j++) begin : g_p
    assign p_s[31-j] = s_s[32 - int'(P_TBL[8*(31-j) +: 8])];
  end

  assign l_out = r_in;
  assign r_out = l_in ^ p_s;
endmodule

module des_iter_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ack,
  input  logic        dec,
  input  logic [63:0] k,
  input  logic [63:0] m,
  output logic [63:0] r,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_e;

  // Rounds whose key-half rotation is one position (all others rotate by two).
  localparam logic [15:0] ENC_ONE = 16'b1000_0001_0000_0011;
  localparam logic [15:0] DEC_ONE = 16'b1000_0001_0000_0010;

  state_e      state_q, state_d;
  logic [31:0] lh_q, lh_d, rh_q, rh_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  i_q, i_d;
  logic        mode_q, mode_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic [63:0] res_q, res_d;

  logic [1:0]  shamt_s;
  logic [27:0] c_rot_s, d_rot_s;
  logic [63:0] ip_s, fp_s;
  logic [55:0] pc1_s;
  logic [47:0] subkey_s;
  logic [31:0] l_nx_s, r_nx_s;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    case (s)
      2'd1:    rotl28 = {x[26:0], x[27]};
      2'd2:    rotl28 = {x[25:0], x[27:26]};
      default: rotl28 = x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    case (s)
      2'd1:    rotr28 = {x[0], x[27:1]};
      2'd2:    rotr28 = {x[1:0], x[27:2]};
      default: rotr28 = x;
    endcase
  endfunction

  perm_IP  u_ip  (.din(m), .dout(ip_s));
  perm_PC1 u_pc1 (.din(k), .dout(pc1_s));
  perm_PC2 u_pc2 (.din({c_rot_s, d_rot_s}), .dout(subkey_s));
  round    u_round (.l_in(lh_q), .r_in(rh_q), .subkey(subkey_s), .l_out(l_nx_s), .r_out(r_nx_s));
  perm_FP  u_fp  (.din({r_nx_s, l_nx_s}), .dout(fp_s));

  // Decryption walks the schedule backwards: round 0 reuses the PC1 halves, which equal the last encrypt halves.
  always_comb begin
    shamt_s = 2'd2;
    c_rot_s = c_q;
    d_rot_s = d_q;
    if (mode_q) begin
      if (i_q == 4'd0)       shamt_s = 2'd0;
      else if (DEC_ONE[i_q]) shamt_s = 2'd1;
      else                   shamt_s = 2'd2;
      c_rot_s = rotr28(c_q, shamt_s);
      d_rot_s = rotr28(d_q, shamt_s);
    end else begin
      shamt_s = ENC_ONE[i_q] ? 2'd1 : 2'd2;
      c_rot_s = rotl28(c_q, shamt_s);
      d_rot_s = rotl28(d_q, shamt_s);
    end
  end

  always_comb begin
    state_d = state_q;
    lh_d    = lh_q;
    rh_d    = rh_q;
    c_d     = c_q;
    d_d     = d_q;
    i_d     = i_q;
    mode_d  = mode_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          lh_d    = ip_s[63:32];
          rh_d    = ip_s[31:0];
          c_d     = pc1_s[55:28];
          d_d     = pc1_s[27:0];
          mode_d  = dec;
          i_d     = 4'd0;
          busy_d  = 1'b1;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        lh_d   = l_nx_s;
        rh_d   = r_nx_s;
        c_d    = c_rot_s;
        d_d    = d_rot_s;
        i_d    = i_q + 4'd1;
        busy_d = 1'b1;
        if (i_q == 4'd15) begin
          res_d   = fp_s;
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ROUND;
        end
      end
      DONE: begin
        if (!req) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          busy_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lh_q    <= 32'd0;
      rh_q    <= 32'd0;
      c_q     <= 28'd0;
      d_q     <= 28'd0;
      i_q     <= 4'd0;
      mode_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      lh_q    <= lh_d;
      rh_q    <= rh_d;
      c_q     <= c_d;
      d_q     <= d_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      res_q   <= res_d;
    end
  end

  assign ack  = ack_q;
  assign r    = res_q;
  assign busy = busy_q;
endmodule
